// File: rtl/operand_src_pkg.sv
// Shared types and helpers for the operand source pipe: queue state encoding and a
// clog2 helper that never returns less than one bit.
package operand_src_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/operand_src_select.sv
// Combinational operand selection: one slot is a constant, one slot is pre-shifted,
// an out-of-range select yields zero data with the error flag set.
module operand_src_select
   import operand_src_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned NUM_SRC   = 4,
   parameter int unsigned CONST_IDX = 1,
   parameter logic [63:0] CONST_VAL = 64'd4,
   parameter int unsigned SHIFT_IDX = 3,
   parameter int unsigned SHIFT_AMT = 2,
   localparam int unsigned SELW     = clog2(NUM_SRC)
) (
   input  logic [SELW-1:0]          control,
   input  logic [NUM_SRC*WIDTH-1:0] in_data,
   output logic [WIDTH-1:0]         sel_data,
   output logic                     sel_err
);

   localparam logic [SELW:0] NSRC = (SELW+1)'(NUM_SRC);

   logic [WIDTH-1:0] slot_val [NUM_SRC];

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_slot
      if (k == CONST_IDX) begin : g_const
         // The raw input for the constant slot is deliberately discarded.
         logic unused_slot;
         assign unused_slot = ^in_data[k*WIDTH +: WIDTH];
         assign slot_val[k] = CONST_VAL[WIDTH-1:0];
      end else if (k == SHIFT_IDX) begin : g_shift
         assign slot_val[k] = in_data[k*WIDTH +: WIDTH] << SHIFT_AMT;
      end else begin : g_pass
         assign slot_val[k] = in_data[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      sel_data = '0;
      sel_err  = 1'b0;
      if ({1'b0, control} >= NSRC) begin
         sel_err = 1'b1;
      end else begin
         for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (control == SELW'(k)) sel_data = slot_val[k];
         end
      end
   end

endmodule

// File: rtl/operand_src_pipe.sv
// Operand source selection feeding a two-entry skid queue; in_ready depends only on
// queue state so the upstream path never sees a combinational path from out_ready.
module operand_src_pipe
   import operand_src_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned NUM_SRC   = 4,
   parameter int unsigned CONST_IDX = 1,
   parameter logic [63:0] CONST_VAL = 64'd4,
   parameter int unsigned SHIFT_IDX = 3,
   parameter int unsigned SHIFT_AMT = 2,
   localparam int unsigned SELW     = clog2(NUM_SRC)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [SELW-1:0]          control,
   input  logic [NUM_SRC*WIDTH-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_err,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               occupancy
);

   if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
      $error("operand_src_pipe: WIDTH must be within 8..64");
   end
   if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_num_src
      $error("operand_src_pipe: NUM_SRC must be within 2..8");
   end
   if (CONST_IDX >= NUM_SRC || SHIFT_IDX >= NUM_SRC) begin : g_bad_idx
      $error("operand_src_pipe: CONST_IDX and SHIFT_IDX must be below NUM_SRC");
   end
   if (CONST_IDX == SHIFT_IDX) begin : g_same_idx
      $error("operand_src_pipe: CONST_IDX and SHIFT_IDX must differ");
   end
   if (SHIFT_AMT >= WIDTH) begin : g_bad_shift
      $error("operand_src_pipe: SHIFT_AMT must be below WIDTH");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] head_data_q, skid_data_q, sel_data;
   logic             head_err_q, skid_err_q, sel_err;
   logic             accept, pop;
   logic             load_head_new, load_head_skid, load_skid;

   operand_src_select #(
      .WIDTH     (WIDTH),
      .NUM_SRC   (NUM_SRC),
      .CONST_IDX (CONST_IDX),
      .CONST_VAL (CONST_VAL),
      .SHIFT_IDX (SHIFT_IDX),
      .SHIFT_AMT (SHIFT_AMT)
   ) u_select (
      .control  (control),
      .in_data  (in_data),
      .sel_data (sel_data),
      .sel_err  (sel_err)
   );

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_data  = head_data_q;
   assign out_err   = head_err_q;

   always_comb begin
      state_d        = state_q;
      load_head_new  = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d       = ONE;
               load_head_new = 1'b1;
            end
         end
         ONE: begin
            if (accept && pop) begin
               load_head_new = 1'b1;
            end else if (accept) begin
               state_d   = FULL;
               load_skid = 1'b1;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_d        = ONE;
               load_head_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      occupancy = 2'd0;
      unique case (state_q)
         ONE:     occupancy = 2'd1;
         FULL:    occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Head is cleared on reset so the idle output reads zero; otherwise entries hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_data_q <= '0;
         head_err_q  <= 1'b0;
         skid_data_q <= '0;
         skid_err_q  <= 1'b0;
      end else begin
         if (load_head_new) begin
            head_data_q <= sel_data;
            head_err_q  <= sel_err;
         end else if (load_head_skid) begin
            head_data_q <= skid_data_q;
            head_err_q  <= skid_err_q;
         end
         if (load_skid) begin
            skid_data_q <= sel_data;
            skid_err_q  <= sel_err;
         end
      end
   end

endmodule
